// File: rtl/bp_be_stride_prefetch_engine.sv
// Stride prefetcher: PC-tagged direct-mapped RPT with per-entry confidence FSM and a burst issue FSM.
// Optional feature macro: BP_BE_STRIDE_STORE_TRAIN_EN (stores train and trigger like loads).
module bp_be_stride_prefetch_engine #(
  parameter int vaddr_width_p  = 39,
  parameter int rpt_sets_p     = 32,
  parameter int tag_width_p    = 10,
  parameter int stride_width_p = 12,
  parameter int degree_p       = 2,
  parameter int page_offset_p  = 12
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     train_v_i,
  input  logic                     train_is_store_i,
  input  logic [vaddr_width_p-1:0] train_pc_i,
  input  logic [vaddr_width_p-1:0] train_addr_i,
  output logic                     pf_v_o,
  input  logic                     pf_ready_i,
  output logic [vaddr_width_p-1:0] pf_addr_o,
  output logic [vaddr_width_p-1:0] pf_pc_o,
  output logic                     busy_o
);

  localparam int IDX_W = $clog2(rpt_sets_p);
  localparam int CNT_W = 4;
  localparam int PG_W  = vaddr_width_p - page_offset_p;
  localparam int HI_W  = vaddr_width_p - stride_width_p + 1;

  typedef enum logic [1:0] {INIT, TRANSIENT, STEADY, NOPRED} rpt_state_e;
  typedef enum logic {IDLE, ISSUE} issue_state_e;

  function automatic logic [vaddr_width_p-1:0] sext_stride(input logic signed [stride_width_p-1:0] s);
    return {{(vaddr_width_p-stride_width_p){s[stride_width_p-1]}}, s};
  endfunction

  // A delta fits when every bit from the stride sign bit upward agrees
  function automatic logic delta_fits(input logic [vaddr_width_p-1:0] d);
    logic [HI_W-1:0] hi;
    hi = d[vaddr_width_p-1:stride_width_p-1];
    return (&hi) | ~(|hi);
  endfunction

  logic [rpt_sets_p-1:0]            v_q;
  logic [tag_width_p-1:0]           tag_q    [rpt_sets_p];
  logic [vaddr_width_p-1:0]         last_q   [rpt_sets_p];
  logic signed [stride_width_p-1:0] stride_q [rpt_sets_p];
  rpt_state_e                       st_q     [rpt_sets_p];

  logic                             sample_en;
  logic [IDX_W-1:0]                 idx;
  logic [tag_width_p-1:0]           tag;
  logic                             hit;
  logic [vaddr_width_p-1:0]         delta;
  logic                             fits;
  logic                             match;
  rpt_state_e                       cur_st, new_st;
  logic signed [stride_width_p-1:0] cur_stride, new_stride, delta_stride;
  logic                             trigger;
  logic                             unused_bits;

`ifdef BP_BE_STRIDE_STORE_TRAIN_EN
  assign sample_en = train_v_i;
`else
  assign sample_en = train_v_i & ~train_is_store_i;
`endif

  assign unused_bits = ^{train_pc_i[1:0], train_pc_i[vaddr_width_p-1:2+IDX_W+tag_width_p],
                         train_is_store_i};

  assign idx        = train_pc_i[2 +: IDX_W];
  assign tag        = train_pc_i[2+IDX_W +: tag_width_p];
  assign cur_st     = st_q[idx];
  assign cur_stride = stride_q[idx];
  assign hit        = sample_en & v_q[idx] & (tag_q[idx] == tag);
  assign delta      = train_addr_i - last_q[idx];
  assign fits       = delta_fits(delta);
  assign match      = fits & (delta == sext_stride(cur_stride));
  assign delta_stride = fits ? delta[stride_width_p-1:0] : '0;

  always_comb begin
    new_st     = cur_st;
    new_stride = cur_stride;
    case (cur_st)
      INIT: begin
        if (match) new_st = STEADY;
        else begin
          new_stride = delta_stride;
          new_st     = TRANSIENT;
        end
      end
      TRANSIENT: begin
        if (match) new_st = STEADY;
        else begin
          new_stride = delta_stride;
          new_st     = NOPRED;
        end
      end
      STEADY: begin
        if (!match) begin
          new_st = INIT;
          if (!fits) new_stride = '0;
        end
      end
      NOPRED: begin
        if (match) new_st = TRANSIENT;
        else       new_stride = delta_stride;
      end
      default: new_st = INIT;
    endcase
  end

  assign trigger = hit & match & (new_st == STEADY) & (cur_stride != '0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) v_q <= '0;
    else if (sample_en) v_q[idx] <= 1'b1;
  end

  // Entry payload is qualified by v_q, so it carries no reset
  always_ff @(posedge clk_i) begin
    if (sample_en) begin
      last_q[idx] <= train_addr_i;
      if (hit) begin
        stride_q[idx] <= new_stride;
        st_q[idx]     <= new_st;
      end else begin
        tag_q[idx]    <= tag;
        stride_q[idx] <= '0;
        st_q[idx]     <= INIT;
      end
    end
  end

  issue_state_e                     state_q, state_d;
  logic [vaddr_width_p-1:0]         nxt_q, nxt_d;
  logic [vaddr_width_p-1:0]         pc_q, pc_d;
  logic [PG_W-1:0]                  base_pg_q, base_pg_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic signed [stride_width_p-1:0] bstride_q, bstride_d;

  logic                     hs;
  logic [vaddr_width_p-1:0] nxt_inc;
  logic                     inc_cross;
  logic                     burst_end;
  logic                     accept;
  logic [vaddr_width_p-1:0] entry_nxt;
  logic                     entry_cross;

  assign hs          = pf_v_o & pf_ready_i;
  assign nxt_inc     = nxt_q + sext_stride(bstride_q);
  assign inc_cross   = nxt_inc[vaddr_width_p-1:page_offset_p] != base_pg_q;
  assign burst_end   = hs & ((cnt_q == CNT_W'(degree_p)) | inc_cross);
  assign accept      = trigger & ((state_q == IDLE) | burst_end);
  assign entry_nxt   = train_addr_i + sext_stride(cur_stride);
  assign entry_cross = entry_nxt[vaddr_width_p-1:page_offset_p] !=
                       train_addr_i[vaddr_width_p-1:page_offset_p];

  always_comb begin
    state_d   = state_q;
    nxt_d     = nxt_q;
    pc_d      = pc_q;
    base_pg_d = base_pg_q;
    cnt_d     = cnt_q;
    bstride_d = bstride_q;
    case (state_q)
      IDLE: ;
      ISSUE: begin
        if (burst_end) state_d = IDLE;
        else if (hs) begin
          nxt_d = nxt_inc;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A first address already outside the base page suppresses the whole burst
    if (accept && !entry_cross) begin
      state_d   = ISSUE;
      nxt_d     = entry_nxt;
      pc_d      = train_pc_i;
      base_pg_d = train_addr_i[vaddr_width_p-1:page_offset_p];
      cnt_d     = CNT_W'(1);
      bstride_d = cur_stride;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      nxt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    base_pg_q <= base_pg_d;
    cnt_q     <= cnt_d;
    bstride_q <= bstride_d;
  end

  assign pf_v_o    = (state_q == ISSUE);
  assign busy_o    = (state_q == ISSUE);
  assign pf_addr_o = nxt_q;
  assign pf_pc_o   = pc_q;

endmodule

// File: tb/tb_bp_be_stride_prefetch_engine.sv
// Bench for bp_be_stride_prefetch_engine: table-driven training sequences with a prefetch scoreboard,
// plus hand-written backpressure, thrash, store and reset-abort sequences.
module tb_bp_be_stride_prefetch_engine;

  localparam int VA = 39;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          train_v, train_is_store, pf_ready;
  logic [VA-1:0] train_pc, train_addr;
  logic          pf_v, busy;
  logic [VA-1:0] pf_addr, pf_pc;

  bp_be_stride_prefetch_engine dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .train_v_i        (train_v),
    .train_is_store_i (train_is_store),
    .train_pc_i       (train_pc),
    .train_addr_i     (train_addr),
    .pf_v_o           (pf_v),
    .pf_ready_i       (pf_ready),
    .pf_addr_o        (pf_addr),
    .pf_pc_o          (pf_pc),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VA-1:0] addr;
    logic [VA-1:0] pc;
  } pf_t;

  typedef struct {
    logic [VA-1:0] pc;
    logic [VA-1:0] a0, a1, a2;
    int            n;
    logic [VA-1:0] e0, e1;
  } vec_t;

  pf_t  exp_q[$];
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  int   pf_v_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && pf_v) pf_v_cycles++;
    if (reset_n && pf_v && pf_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pf: got addr %0h pc %0h expected no request", pf_addr, pf_pc);
      end else begin
        pf_t e;
        e = exp_q.pop_front();
        check("pf_addr", pf_addr, e.addr);
        check("pf_pc", pf_pc, e.pc);
      end
    end
  end

  task automatic drive(input logic [VA-1:0] pc, input logic [VA-1:0] addr, input logic st);
    @(posedge clk); #1;
    train_v        = 1'b1;
    train_pc       = pc;
    train_addr     = addr;
    train_is_store = st;
  endtask

  task automatic idle_cyc();
    @(posedge clk); #1;
    train_v        = 1'b0;
    train_is_store = 1'b0;
  endtask

  task automatic push(input logic [VA-1:0] addr, input logic [VA-1:0] pc);
    pf_t e;
    e.addr = addr;
    e.pc   = pc;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((busy || exp_q.size() != 0) && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({name, "_remaining"}, exp_q.size(), 0);
    check({name, "_idle"}, busy, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{39'h80000100, 39'h1000, 39'h1040, 39'h1080, 2, 39'h10C0, 39'h1100};
    vecs[1] = '{39'h80000200, 39'h2030, 39'h2028, 39'h2020, 2, 39'h2018, 39'h2010};
    // Negative stride whose first target falls below the base page: suppressed on entry
    vecs[2] = '{39'h80000104, 39'h2010, 39'h2008, 39'h2000, 0, 39'h0,    39'h0};
    vecs[3] = '{39'h80000108, 39'h1F00, 39'h1F40, 39'h1F80, 1, 39'h1FC0, 39'h0};
    vecs[4] = '{39'h8000010C, 39'h4000, 39'h4800, 39'h5000, 0, 39'h0,    39'h0};
    vecs[5] = '{39'h80000110, 39'h7000, 39'h73FF, 39'h77FE, 2, 39'h7BFD, 39'h7FFC};
    vecs[6] = '{39'h80000114, 39'h9000, 39'h9000, 39'h9000, 0, 39'h0,    39'h0};

    reset_n = 1'b0;
    train_v = 1'b0;
    train_is_store = 1'b0;
    train_pc = '0;
    train_addr = '0;
    pf_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pf_v", pf_v, 1'b0);
    check("rst_pf_addr", pf_addr, 0);
    check("rst_pf_pc", pf_pc, 0);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].pc, vecs[i].a0, 1'b0);
      drive(vecs[i].pc, vecs[i].a1, 1'b0);
      drive(vecs[i].pc, vecs[i].a2, 1'b0);
      if (vecs[i].n >= 1) push(vecs[i].e0, vecs[i].pc);
      if (vecs[i].n >= 2) push(vecs[i].e1, vecs[i].pc);
      idle_cyc();
      drain($sformatf("vec%0d", i));
    end

    pf_ready = 1'b0;
    drive(39'h80000300, 39'h1000, 1'b0);
    drive(39'h80000300, 39'h1040, 1'b0);
    drive(39'h80000300, 39'h1080, 1'b0);
    push(39'h10C0, 39'h80000300);
    push(39'h1100, 39'h80000300);
    idle_cyc();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_pf_v", pf_v, 1'b1);
      check("bp_pf_addr", pf_addr, 39'h10C0);
    end
    @(posedge clk); #1;
    pf_ready = 1'b1;
    drain("backpressure");

    pf_v_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      drive(39'h100, 39'h1000 + 39'(i) * 39'h40, 1'b0);
      drive(39'h180, 39'h8000 + 39'(i) * 39'h40, 1'b0);
    end
    idle_cyc();
    repeat (4) @(negedge clk);
    check("thrash_no_pf", pf_v_cycles, 0);

    drive(39'h80000400, 39'h3000, 1'b1);
    drive(39'h80000400, 39'h3008, 1'b1);
    drive(39'h80000400, 39'h3010, 1'b1);
`ifdef BP_BE_STRIDE_STORE_TRAIN_EN
    push(39'h3018, 39'h80000400);
    push(39'h3020, 39'h80000400);
`endif
    idle_cyc();
    drain("store");

    pf_ready = 1'b0;
    drive(39'h80000500, 39'h6000, 1'b0);
    drive(39'h80000500, 39'h6040, 1'b0);
    drive(39'h80000500, 39'h6080, 1'b0);
    idle_cyc();
    begin
      int k = 0;
      while (!pf_v && k < 10) begin
        @(negedge clk);
        k++;
      end
    end
    check("abort_burst_started", pf_v, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_pf_v", pf_v, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_pf_addr", pf_addr, 0);
    check("abort_pf_pc", pf_pc, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    pf_ready = 1'b1;
    // Table was cleared, so continuing the old stride must retrain from scratch
    drive(39'h80000500, 39'h60C0, 1'b0);
    drive(39'h80000500, 39'h6100, 1'b0);
    idle_cyc();
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
